// File: rtl/digit_latch_sequencer.sv
// Sequencer for the D_Latch digit cell: turns handshaked read/write
// requests into timed InputData / WriteEdge / ReadEdge strobes.
module digit_latch_sequencer #(
   parameter int DIGIT_W   = 2,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic               Clock,
   input  logic               nReset,
   input  logic               ReqValid,
   output logic               ReqReady,
   input  logic               ReqWrite,
   input  logic [DIGIT_W-1:0] ReqData,
   output logic               RspValid,
   input  logic               RspReady,
   output logic [DIGIT_W-1:0] RspData,
   output logic               RspErr,
   output logic               WrErr,
   output logic [DIGIT_W-1:0] InputData,
   output logic               WriteEdge,
   output logic               ReadEdge,
   input  logic [DIGIT_W-1:0] OutputData
);

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      R_PULSE,
      RESP
   } state_t;

   localparam logic [DIGIT_W-1:0] BAD = '1;
   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               rvalid_q, rvalid_d;
   logic [DIGIT_W-1:0] rdata_q, rdata_d;
   logic               rerr_q, rerr_d;
   logic               wrerr_q, wrerr_d;
   logic [DIGIT_W-1:0] idata_q, idata_d;
   logic               wedge_q, wedge_d;
   logic               redge_q, redge_d;

   logic acc;
   logic last;
   logic wr_ok;
   logic wr_bad;
   logic sample;

   assign acc    = ReqValid & ready_q;
   assign last   = (cnt_q == 4'd0);
   assign wr_ok  = acc & ReqWrite & (ReqData != BAD);
   assign wr_bad = acc & ReqWrite & (ReqData == BAD);
   assign sample = (state_q == R_PULSE) & last;

   // state and output registers, synchronous active-low reset
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         ready_q  <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
         wrerr_q  <= 1'b0;
         idata_q  <= '0;
         wedge_q  <= 1'b0;
         redge_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
         wrerr_q  <= wrerr_d;
         idata_q  <= idata_d;
         wedge_q  <= wedge_d;
         redge_q  <= redge_d;
      end
   end

   // phase sequencing; counter reloads on entry to each phase
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (acc && !ReqWrite) begin
               state_d = R_PULSE;
               cnt_d   = PULSE_LD;
            end else if (wr_ok) begin
               state_d = W_SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         W_SETUP: begin
            if (last) begin
               state_d = W_PULSE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         W_PULSE: begin
            if (!last) begin
               cnt_d = cnt_q - 4'd1;
            end else if (HOLD_CYC == 0) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               state_d = W_HOLD;
               cnt_d   = HOLD_LD;
            end
         end
         W_HOLD: begin
            if (last) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         R_PULSE: begin
            if (last) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rvalid_q && RspReady) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // next values of the registered outputs, derived from next state
   always_comb begin
      ready_d  = (state_d == IDLE);
      wedge_d  = (state_d == W_PULSE);
      redge_d  = (state_d == R_PULSE);
      rvalid_d = (state_d == RESP);
      wrerr_d  = wr_bad;
      idata_d  = wr_ok ? ReqData : idata_q;
      rdata_d  = sample ? OutputData : rdata_q;
      rerr_d   = sample ? (OutputData == BAD) : rerr_q;
   end

   assign ReqReady  = ready_q;
   assign RspValid  = rvalid_q;
   assign RspData   = rdata_q;
   assign RspErr    = rerr_q;
   assign WrErr     = wrerr_q;
   assign InputData = idata_q;
   assign WriteEdge = wedge_q;
   assign ReadEdge  = redge_q;

endmodule

// File: tb/tb_digit_latch_sequencer.sv
// Directed bench for digit_latch_sequencer with a behavioural
// model of the D_Latch cell used for the back-to-back test.
module tb_digit_latch_sequencer;

   logic       Clock;
   logic       nReset;
   logic       ReqValid;
   logic       ReqReady;
   logic       ReqWrite;
   logic [1:0] ReqData;
   logic       RspValid;
   logic       RspReady;
   logic [1:0] RspData;
   logic       RspErr;
   logic       WrErr;
   logic [1:0] InputData;
   logic       WriteEdge;
   logic       ReadEdge;
   logic [1:0] OutputData;

   logic [1:0] od_drv;
   logic [1:0] latch_m;
   logic       use_model;

   int total;
   int bad;

   digit_latch_sequencer dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .ReqValid   (ReqValid),
      .ReqReady   (ReqReady),
      .ReqWrite   (ReqWrite),
      .ReqData    (ReqData),
      .RspValid   (RspValid),
      .RspReady   (RspReady),
      .RspData    (RspData),
      .RspErr     (RspErr),
      .WrErr      (WrErr),
      .InputData  (InputData),
      .WriteEdge  (WriteEdge),
      .ReadEdge   (ReadEdge),
      .OutputData (OutputData)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // latch cell model: transparent capture while WriteEdge is high
   always @(posedge Clock) begin
      if (WriteEdge) latch_m <= InputData;
   end

   assign OutputData = use_model ? latch_m : od_drv;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [15:0] outs();
      return {6'd0, ReqReady, RspValid, RspData, RspErr, WrErr,
              InputData, WriteEdge, ReadEdge};
   endfunction

   initial begin
      total     = 0;
      bad       = 0;
      latch_m   = 2'b00;
      use_model = 1'b0;
      od_drv    = 2'b00;
      nReset    = 1'b0;
      ReqValid  = 1'b1;
      ReqWrite  = 1'b1;
      ReqData   = 2'b10;
      RspReady  = 1'b0;

      // T1 reset with a request pending
      tick();
      chk("rst_c1_outs", outs(), 16'd0);
      tick();
      chk("rst_c2_outs", outs(), 16'd0);
      nReset   = 1'b1;
      ReqValid = 1'b0;
      tick();
      chk("rst_rel_ready", 16'(ReqReady), 16'd1);
      chk("rst_rel_valid", 16'(RspValid), 16'd0);

      // T2 write 2'b10
      ReqValid = 1'b1;
      ReqWrite = 1'b1;
      ReqData  = 2'b10;
      tick();
      ReqValid = 1'b0;
      chk("wr_c1_idata", 16'(InputData), 16'd2);
      chk("wr_c1_wedge", 16'(WriteEdge), 16'd0);
      chk("wr_c1_ready", 16'(ReqReady), 16'd0);
      tick();
      chk("wr_c2_wedge", 16'(WriteEdge), 16'd1);
      tick();
      chk("wr_c3_wedge", 16'(WriteEdge), 16'd1);
      chk("wr_c3_idata", 16'(InputData), 16'd2);
      tick();
      chk("wr_c4_wedge", 16'(WriteEdge), 16'd0);
      chk("wr_c4_idata", 16'(InputData), 16'd2);
      chk("wr_c4_ready", 16'(ReqReady), 16'd0);
      tick();
      chk("wr_c5_ready", 16'(ReqReady), 16'd1);

      // T3 read with backpressure; sample taken on last pulse edge
      od_drv   = 2'b11;
      ReqValid = 1'b1;
      ReqWrite = 1'b0;
      tick();
      ReqValid = 1'b0;
      chk("rd_c1_redge", 16'(ReadEdge), 16'd1);
      chk("rd_c1_wedge", 16'(WriteEdge), 16'd0);
      od_drv = 2'b01;
      tick();
      chk("rd_c2_redge", 16'(ReadEdge), 16'd1);
      chk("rd_c2_valid", 16'(RspValid), 16'd0);
      tick();
      od_drv = 2'b10;
      chk("rd_c3_redge", 16'(ReadEdge), 16'd0);
      chk("rd_c3_valid", 16'(RspValid), 16'd1);
      chk("rd_c3_data", 16'(RspData), 16'd1);
      chk("rd_c3_err", 16'(RspErr), 16'd0);
      chk("rd_c3_ready", 16'(ReqReady), 16'd0);
      tick();
      chk("rd_c4_hold", {12'd0, RspValid, RspErr, RspData}, 16'h9);
      tick();
      chk("rd_c5_hold", {12'd0, RspValid, RspErr, RspData}, 16'h9);
      RspReady = 1'b1;
      tick();
      RspReady = 1'b0;
      chk("rd_hs_valid", 16'(RspValid), 16'd0);
      chk("rd_hs_ready", 16'(ReqReady), 16'd1);

      // T4 invalid digit write
      ReqValid = 1'b1;
      ReqWrite = 1'b1;
      ReqData  = 2'b11;
      tick();
      ReqValid = 1'b0;
      chk("bad_c1_wrerr", 16'(WrErr), 16'd1);
      chk("bad_c1_wedge", 16'(WriteEdge), 16'd0);
      chk("bad_c1_idata", 16'(InputData), 16'd2);
      chk("bad_c1_ready", 16'(ReqReady), 16'd1);
      tick();
      chk("bad_c2_wrerr", 16'(WrErr), 16'd0);
      chk("bad_c2_wedge", 16'(WriteEdge), 16'd0);
      chk("bad_c2_idata", 16'(InputData), 16'd2);

      // T4 invalid digit read
      od_drv   = 2'b11;
      ReqValid = 1'b1;
      ReqWrite = 1'b0;
      tick();
      ReqValid = 1'b0;
      tick();
      tick();
      chk("badrd_valid", 16'(RspValid), 16'd1);
      chk("badrd_err", 16'(RspErr), 16'd1);
      chk("badrd_data", 16'(RspData), 16'd3);
      RspReady = 1'b1;
      tick();
      RspReady = 1'b0;
      chk("badrd_hs", 16'(RspValid), 16'd0);

      // T5 reset in the first pulse cycle of a write
      ReqValid = 1'b1;
      ReqWrite = 1'b1;
      ReqData  = 2'b01;
      tick();
      ReqValid = 1'b0;
      tick();
      chk("midrst_pulse", 16'(WriteEdge), 16'd1);
      nReset = 1'b0;
      tick();
      chk("midrst_outs", outs(), 16'd0);
      nReset = 1'b1;
      tick();
      chk("midrst_ready", 16'(ReqReady), 16'd1);
      for (int i = 0; i < 4; i++) begin
         chk("midrst_quiet", {14'd0, RspValid, WriteEdge}, 16'd0);
         tick();
      end

      // T6 write then read queued with ReqValid held high
      use_model = 1'b1;
      ReqValid  = 1'b1;
      ReqWrite  = 1'b1;
      ReqData   = 2'b10;
      tick();
      ReqWrite = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk("b2b_blocked", 16'(ReqReady), 16'd0);
         chk("b2b_overlap", 16'(WriteEdge & ReadEdge), 16'd0);
         tick();
      end
      chk("b2b_c5_ready", 16'(ReqReady), 16'd1);
      tick();
      ReqValid = 1'b0;
      chk("b2b_c6_redge", 16'(ReadEdge), 16'd1);
      chk("b2b_c6_wedge", 16'(WriteEdge), 16'd0);
      tick();
      chk("b2b_c7_redge", 16'(ReadEdge), 16'd1);
      tick();
      chk("b2b_c8_valid", 16'(RspValid), 16'd1);
      chk("b2b_c8_data", 16'(RspData), 16'(latch_m));
      chk("b2b_c8_val2", 16'(RspData), 16'd2);
      RspReady = 1'b1;
      tick();
      RspReady = 1'b0;
      chk("b2b_done", {14'd0, RspValid, ReqReady}, 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
